timer_counter: RTL and testbench

//  Memory-mapped down-counting timer device on the bridge, downstream of the memory stage.

---
 rtl/timer_counter_pkg.sv | 20 ++
 rtl/timer_counter.sv | 108 ++++++++++
 tb/tb_timer_counter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// Shared register-map, mode and FSM state definitions for the down-counting timer.
package timer_counter_pkg;

    localparam logic [1:0] TIMER_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_ADDR_PRESET = 2'd1;
    localparam logic [1:0] TIMER_ADDR_COUNT  = 2'd2;

    localparam logic [1:0] TIMER_MODE_ONESHOT = 2'd0;
    localparam logic [1:0] TIMER_MODE_RELOAD  = 2'd1;

    localparam int TIMER_STATE_LEN = 2;

    typedef enum logic [TIMER_STATE_LEN-1:0] {
        TIMER_STATE_IDLE = 2'd0,
        TIMER_STATE_LOAD = 2'd1,
        TIMER_STATE_CNT  = 2'd2,
        TIMER_STATE_INT  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer: CTRL/PRESET/COUNT registers, count FSM and level interrupt.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic             en_r;
    logic [1:0]       mode_r;
    logic             im_r;
    logic [CNT_W-1:0] preset_r;
    logic [CNT_W-1:0] count_r;
    logic             irq_flag_r;
    timer_state_e     state_r;
    logic             unused_s;

    // Only the low two word-address bits select a register.
    assign unused_s = ^addr[29:2];

    // Count FSM acts on pre-write CTRL; a same-edge bus write then overrides the registers it touches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r       <= 1'b0;
            mode_r     <= 2'b00;
            im_r       <= 1'b0;
            preset_r   <= '0;
            count_r    <= '0;
            irq_flag_r <= 1'b0;
            state_r    <= TIMER_STATE_IDLE;
        end else begin
            if (!en_r) begin
                state_r <= TIMER_STATE_IDLE;
            end else begin
                case (state_r)
                    TIMER_STATE_IDLE: begin
                        state_r <= TIMER_STATE_LOAD;
                    end
                    TIMER_STATE_LOAD: begin
                        count_r <= preset_r;
                        state_r <= TIMER_STATE_CNT;
                    end
                    TIMER_STATE_CNT: begin
                        if (count_r > CNT_ONE) begin
                            count_r <= count_r - CNT_ONE;
                        end else begin
                            count_r    <= '0;
                            irq_flag_r <= 1'b1;
                            state_r    <= TIMER_STATE_INT;
                        end
                    end
                    TIMER_STATE_INT: begin
                        // Modes 2/3 fall through to one-shot behaviour.
                        if (mode_r == TIMER_MODE_RELOAD) begin
                            irq_flag_r <= 1'b0;
                            state_r    <= TIMER_STATE_LOAD;
                        end else begin
                            en_r    <= 1'b0;
                            state_r <= TIMER_STATE_IDLE;
                        end
                    end
                    default: begin
                        state_r <= TIMER_STATE_IDLE;
                    end
                endcase
            end

            if (we) begin
                case (addr[1:0])
                    TIMER_ADDR_CTRL: begin
                        en_r       <= din[0];
                        mode_r     <= din[2:1];
                        im_r       <= din[3];
                        irq_flag_r <= 1'b0;
                    end
                    TIMER_ADDR_PRESET: begin
                        preset_r <= din[CNT_W-1:0];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Read mux over the register map; COUNT and unmapped slots are not writable.
    always_comb begin
        dout = 32'h0000_0000;
        case (addr[1:0])
            TIMER_ADDR_CTRL:   dout = {28'h000_0000, im_r, mode_r, en_r};
            TIMER_ADDR_PRESET: dout = 32'(preset_r);
            TIMER_ADDR_COUNT:  dout = 32'(count_r);
            default:           dout = 32'h0000_0000;
        endcase
    end

    assign irq = im_r & irq_flag_r;

endmodule

// File: tb/tb_timer_counter.sv
// Directed and randomized checks of timer_counter against an edge-counting reference model.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [29:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_compared;
    int n_mismatched;

    // Reference model: register contents plus "edges since the run was armed".
    logic        m_en;
    logic [1:0]  m_mode;
    logic        m_im;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic [31:0] m_p0;
    logic        m_flag;
    bit          m_busy;
    int          m_t;
    int          m_len;

    timer_counter #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic model_reset();
        m_en = 1'b0; m_mode = 2'd0; m_im = 1'b0;
        m_preset = 32'd0; m_count = 32'd0; m_p0 = 32'd0;
        m_flag = 1'b0; m_busy = 1'b0; m_t = 0; m_len = 0;
    endtask

    // One clock edge: timing behaviour uses pre-edge values, then the bus write is applied.
    task automatic model_edge(input bit w, input logic [1:0] a, input logic [31:0] d);
        if (!m_en) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            m_busy = 1'b1;
            m_t = 0;
        end else begin
            m_t = m_t + 1;
            if (m_t == 1) begin
                m_p0    = m_preset;
                m_len   = (m_preset == 32'd0) ? 1 : int'(m_preset);
                m_count = m_preset;
            end else if (m_t <= m_len) begin
                m_count = m_p0 - 32'(m_t - 1);
            end else if (m_t == m_len + 1) begin
                m_count = 32'd0;
                m_flag  = 1'b1;
            end else if (m_mode == 2'd1) begin
                m_flag = 1'b0;
                m_t    = 0;
            end else begin
                m_en   = 1'b0;
                m_busy = 1'b0;
            end
        end
        if (w && a == 2'd0) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 1'b0;
        end else if (w && a == 2'd1) begin
            m_preset = d;
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0:       return {28'd0, m_im, m_mode, m_en};
            1:       return m_preset;
            2:       return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        assert (got === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reads all four registers combinationally and checks irq against the model.
    task automatic check_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            addr = {28'($urandom), 2'(a)};
            #1;
            expect_val($sformatf("%s dout[%0d]", tag, a), dout, model_read(a));
        end
        expect_val({tag, " irq"}, {31'd0, irq}, {31'd0, m_im & m_flag});
    endtask

    task automatic tick(input bit w, input logic [1:0] a, input logic [31:0] d, input string tag);
        @(negedge clk);
        we   = w;
        addr = {28'($urandom), a};
        din  = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        we = 1'b0;
        check_all(tag);
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        addr = {28'd0, a};
        #1;
        v = dout;
    endtask

    initial begin
        logic [31:0] v;
        int          pulses;
        int          guard;
        int          r;
        n_compared   = 0;
        n_mismatched = 0;
        we = 1'b0; addr = 30'd0; din = 32'd0;
        reset = 1'b1;
        model_reset();

        // Asynchronous reset with no clock edge in between.
        #3 reset = 1'b0;
        #2 check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // One-shot, PRESET=3, CTRL=0x9 written at edge 0.
        tick(1'b1, 2'd1, 32'd3, "os_preset");
        tick(1'b1, 2'd0, 32'h9, "os_e0");
        for (int i = 1; i <= 5; i++) begin
            tick(1'b0, 2'd0, 32'd0, $sformatf("os_e%0d", i));
            if (i >= 2) begin
                read_reg(2'd2, v);
                expect_val($sformatf("os_count_e%0d", i), v, 32'(5 - i));
            end
        end
        expect_val("os_irq_e5", {31'd0, irq}, 32'd1);
        tick(1'b0, 2'd0, 32'd0, "os_e6");
        read_reg(2'd0, v);
        expect_val("os_ctrl_e6", v, 32'h8);
        tick(1'b0, 2'd0, 32'd0, "os_hold");
        expect_val("os_irq_hold", {31'd0, irq}, 32'd1);
        tick(1'b1, 2'd0, 32'h8, "os_clear");
        expect_val("os_irq_cleared", {31'd0, irq}, 32'd0);

        // Auto-reload: one-cycle pulse every PRESET+2 edges.
        tick(1'b1, 2'd0, 32'hB, "rl_e0");
        pulses = 0;
        for (int i = 1; i <= 15; i++) begin
            tick(1'b0, 2'd0, 32'd0, $sformatf("rl_e%0d", i));
            if (irq === 1'b1) pulses++;
        end
        expect_val("rl_pulses", 32'(pulses), 32'd3);
        tick(1'b1, 2'd0, 32'h0, "rl_stop");

        // Interrupt masked: flag sets internally, irq stays low, CTRL=0x8 clears it.
        tick(1'b1, 2'd0, 32'h1, "im0_e0");
        for (int i = 1; i <= 7; i++) tick(1'b0, 2'd0, 32'd0, "im0_run");
        tick(1'b1, 2'd0, 32'h8, "im0_clear");
        tick(1'b0, 2'd0, 32'd0, "im0_after");

        // Disable mid-count: COUNT frozen one below the value seen at the write edge.
        tick(1'b1, 2'd1, 32'd7, "stop_preset");
        tick(1'b1, 2'd0, 32'h1, "stop_e0");
        guard = 0;
        while (!(m_busy && m_t >= 1 && m_count == 32'd5) && guard < 20) begin
            tick(1'b0, 2'd0, 32'd0, "stop_run");
            guard++;
        end
        expect_val("stop_reach5", 32'(guard < 20), 32'd1);
        tick(1'b1, 2'd0, 32'h0, "stop_write");
        tick(1'b0, 2'd0, 32'd0, "stop_idle1");
        tick(1'b0, 2'd0, 32'd0, "stop_idle2");
        read_reg(2'd2, v);
        expect_val("stop_frozen", v, 32'd4);

        // PRESET rewritten during CNT only takes effect at the next reload.
        tick(1'b1, 2'd1, 32'd4, "pw_preset");
        tick(1'b1, 2'd0, 32'hB, "pw_e0");
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd0, 32'd0, "pw_run");
        tick(1'b1, 2'd1, 32'd9, "pw_write9");
        for (int i = 0; i < 20; i++) tick(1'b0, 2'd0, 32'd0, "pw_cont");
        tick(1'b1, 2'd0, 32'h0, "pw_stop");

        // Writes to COUNT and the unmapped slot are ignored.
        tick(1'b1, 2'd2, 32'h1234, "ro_count");
        tick(1'b1, 2'd3, 32'h1234, "ro_unmapped");

        // PRESET=0 still passes through one counting edge.
        tick(1'b1, 2'd1, 32'd0, "p0_preset");
        tick(1'b1, 2'd0, 32'h9, "p0_e0");
        for (int i = 1; i <= 5; i++) tick(1'b0, 2'd0, 32'd0, $sformatf("p0_e%0d", i));

        // Asynchronous reset mid-count, then stays idle after release.
        tick(1'b1, 2'd1, 32'd6, "mr_preset");
        tick(1'b1, 2'd0, 32'hB, "mr_e0");
        for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 32'd0, "mr_run");
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("mr_reset");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 32'd0, "mr_idle");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 11);
            if (r < 2)       tick(1'b1, 2'd1, 32'($urandom_range(0, 6)), "rnd_preset");
            else if (r < 4)  tick(1'b1, 2'd0, $urandom, "rnd_ctrl");
            else if (r == 4) tick(1'b1, 2'($urandom_range(2, 3)), $urandom, "rnd_ro");
            else             tick(1'b0, 2'($urandom), $urandom, "rnd_idle");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
